hex_display_scanner: RTL and testbench

- Time-multiplexes one shared hex-to-seven-segment decoder across NUM_DIGITS common-anode digits that share a single active-low segment bus.
- Holds a displayed value and a one-deep pending value behind a valid/ready load handshake; new values take effect only at frame boundaries, so a frame never tears.
- Sits between datapath logic producing hex values and the board segment/digit-enable pins.

---
 rtl/hex_display_scanner.sv | 158 +++++++++++++++
 tb/tb_hex_display_scanner.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex seven-segment scanner: one shared decoder, frame-aligned double-buffered loads.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits; digit 0 always shown).
module hex_display_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int GUARD      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_n,
    output logic                    frame_done
);
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CMAX = (DIV > GUARD) ? DIV : GUARD;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int DW   = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {S_IDLE, S_GUARD, S_SHOW} state_t;

    state_t                state, state_next;
    logic [IW-1:0]         idx, idx_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic                  frame_end;
    logic [DW-1:0]         shadow, pending;
    logic                  pend_full;
    logic                  accept, transfer;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] dig_n_next;
    logic [3:0]            nibble;
    logic                  blank;

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h20;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    // Outputs are registered from the next-state view so they change on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            cnt        <= '0;
            seg        <= 7'h7F;
            dig_n      <= '1;
            frame_done <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            cnt        <= cnt_next;
            seg        <= seg_next;
            dig_n      <= dig_n_next;
            frame_done <= frame_end;
            load_ready <= ~(accept | (pend_full & ~transfer));
        end
    end

    assign accept   = load_valid & ~pend_full;
    assign transfer = pend_full & (frame_end | (state == S_IDLE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            pending   <= '0;
            pend_full <= 1'b0;
        end else if (transfer) begin
            shadow    <= pending;
            pend_full <= 1'b0;
        end else if (accept) begin
            pending   <= load_data;
            pend_full <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        frame_end  = 1'b0;
        if (!en) begin
            state_next = S_IDLE;
            idx_next   = '0;
            cnt_next   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_next = S_GUARD;
                    idx_next   = '0;
                    cnt_next   = '0;
                end
                S_GUARD: begin
                    if (cnt == CW'(GUARD - 1)) begin
                        state_next = S_SHOW;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                S_SHOW: begin
                    if (cnt == CW'(DIV - 1)) begin
                        state_next = S_GUARD;
                        cnt_next   = '0;
                        if (idx == IW'(NUM_DIGITS - 1)) begin
                            idx_next  = '0;
                            frame_end = 1'b1;
                        end else begin
                            idx_next = idx + IW'(1);
                        end
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Shadow only changes on edges leading into GUARD or IDLE, so decoding it here never tears a SHOW slot.
    always_comb begin
        nibble     = '0;
        blank      = 1'b0;
        seg_next   = 7'h7F;
        dig_n_next = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_next == IW'(k)) begin
                nibble = shadow[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                if (k > 0 && (shadow >> (4*k)) == '0) blank = 1'b1;
`endif
            end
        end
        if (state_next == S_SHOW && !blank) begin
            seg_next = decode(nibble);
            for (int k = 0; k < NUM_DIGITS; k++) dig_n_next[k] = (idx_next != IW'(k));
        end
    end
endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: directed frame checks plus randomized traffic against a frame-position model.
// Honours LEADING_ZERO_BLANK_EN in both the model and the directed expectations.
module tb_hex_display_scanner;
    localparam int N     = 4;
    localparam int D     = 4;
    localparam int G     = 2;
    localparam int SLOT  = G + D;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic [6:0]  seg;
    logic [3:0]  dig_n;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    hex_display_scanner #(.NUM_DIGITS(N), .DIV(D), .GUARD(G)) dut (
        .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .seg(seg), .dig_n(dig_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h20, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: position within the frame since enable, plus shadow and a one-deep pending slot.
    logic        m_run, m_fd, m_full;
    int          m_pos;
    logic [15:0] m_shadow, m_pend;
    logic [6:0]  m_seg;
    logic [3:0]  m_dig;

    always @(posedge clk or posedge rst) begin : model
        logic run_n, fd_n, xfer;
        int   pos_n;
        if (rst) begin
            m_run <= 1'b0; m_pos <= 0; m_fd <= 1'b0;
            m_shadow <= '0; m_pend <= '0; m_full <= 1'b0;
        end else begin
            fd_n = 1'b0;
            if (!en) begin
                run_n = 1'b0; pos_n = 0; xfer = !m_run && m_full;
            end else if (!m_run) begin
                run_n = 1'b1; pos_n = 0; xfer = m_full;
            end else begin
                run_n = 1'b1; pos_n = (m_pos + 1) % FRAME; fd_n = (pos_n == 0); xfer = fd_n && m_full;
            end
            m_run <= run_n; m_pos <= pos_n; m_fd <= fd_n;
            if (xfer) begin
                m_shadow <= m_pend; m_full <= 1'b0;
            end else if (load_valid && !m_full) begin
                m_pend <= load_data; m_full <= 1'b1;
            end
        end
    end

    always_comb begin
        int  slot, off;
        logic show, blk;
        slot  = m_pos / SLOT;
        off   = m_pos % SLOT;
        show  = m_run && (off >= G);
        blk   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blk   = (slot > 0) && ((m_shadow >> (4*slot)) == 16'h0);
`endif
        m_seg = 7'h7F;
        m_dig = 4'hF;
        if (show && !blk) begin
            m_seg = seg_tab[(m_shadow >> (4*slot)) & 16'hF];
            m_dig = ~(4'b0001 << slot);
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check_output("model seg", 32'(seg), 32'(m_seg));
        check_output("model dig_n", 32'(dig_n), 32'(m_dig));
        check_output("model load_ready", 32'(load_ready), 32'(!m_full));
        check_output("model frame_done", 32'(frame_done), 32'(m_fd));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic e, input logic v, input logic [15:0] d);
        en = e; load_valid = v; load_data = d;
    endtask

    // Called at frame position 0; walks one full frame and ends at position 0 of the next.
    task automatic check_frame(input logic [15:0] dig_exp, input logic [27:0] seg_exp);
        int s, off;
        for (int p = 0; p <= FRAME; p++) begin
            if (p > 0) check_output($sformatf("frame fd p%0d", p), 32'(frame_done), 32'(p == FRAME));
            if (p < FRAME) begin
                s = p / SLOT; off = p % SLOT;
                check_output($sformatf("frame dig p%0d", p), 32'(dig_n),
                             (off < G) ? 32'hF : 32'(dig_exp[4*s +: 4]));
                check_output($sformatf("frame seg p%0d", p), 32'(seg),
                             (off < G) ? 32'h7F : 32'(seg_exp[7*s +: 7]));
                step(1);
            end
        end
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        for (int k = 0; k < 4; k++) v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 16'h0);
        step(3);
        check_output("reset seg", 32'(seg), 32'h7F);
        check_output("reset dig_n", 32'(dig_n), 32'hF);
        check_output("reset load_ready", 32'(load_ready), 32'h1);
        check_output("reset frame_done", 32'(frame_done), 32'h0);
        rst = 1'b0;
        step(1);

        apply_stimulus(1'b0, 1'b1, 16'h1A2F);
        step(1);
        check_output("idle accept ready", 32'(load_ready), 32'h0);
        apply_stimulus(1'b1, 1'b0, 16'h0);
        step(1);
        check_output("idle transfer ready", 32'(load_ready), 32'h1);
        check_frame(16'h7BDE, {7'h79, 7'h20, 7'h24, 7'h0E});

        step(8);
        apply_stimulus(1'b1, 1'b1, 16'h0000);
        step(1);
        check_output("pending ready drop", 32'(load_ready), 32'h0);
        check_output("no tear dig", 32'(dig_n), 32'hD);
        check_output("no tear seg", 32'(seg), 32'h24);
        apply_stimulus(1'b1, 1'b1, 16'h3333);
        step(14);
        check_output("old frame dig3", 32'(dig_n), 32'h7);
        check_output("old frame seg3", 32'(seg), 32'h79);
        check_output("held not accepted", 32'(load_ready), 32'h0);
        step(1);
        check_output("boundary fd", 32'(frame_done), 32'h1);
        check_output("boundary ready", 32'(load_ready), 32'h1);
        step(1);
        check_output("held accepted", 32'(load_ready), 32'h0);
        apply_stimulus(1'b1, 1'b0, 16'h0);
        step(1);
        check_output("zero frame dig", 32'(dig_n), 32'hE);
        check_output("zero frame seg", 32'(seg), 32'h40);
        step(22);
        check_frame(16'h7BDE, {7'h30, 7'h30, 7'h30, 7'h30});

        step(14);
        apply_stimulus(1'b0, 1'b0, 16'h0);
        step(1);
        check_output("en drop seg", 32'(seg), 32'h7F);
        check_output("en drop dig", 32'(dig_n), 32'hF);
        check_output("en drop fd", 32'(frame_done), 32'h0);
        step(2);
        apply_stimulus(1'b1, 1'b0, 16'h0);
        step(1);
        check_output("restart guard", 32'(dig_n), 32'hF);
        step(2);
        check_output("restart dig", 32'(dig_n), 32'hE);
        check_output("restart seg", 32'(seg), 32'h30);

        step(12);
        #2 rst = 1'b1;
        #1;
        check_output("async reset seg", 32'(seg), 32'h7F);
        check_output("async reset dig", 32'(dig_n), 32'hF);
        check_output("async reset ready", 32'(load_ready), 32'h1);
        check_output("async reset fd", 32'(frame_done), 32'h0);
        step(1);
        rst = 1'b0;
        step(2);
        check_output("post reset guard", 32'(dig_n), 32'hF);
        step(1);
        check_output("post reset dig", 32'(dig_n), 32'hE);
        check_output("post reset seg", 32'(seg), 32'h40);

        apply_stimulus(1'b0, 1'b1, 16'h0005);
        step(1);
        apply_stimulus(1'b1, 1'b0, 16'h0);
        step(1);
`ifdef LEADING_ZERO_BLANK_EN
        check_frame(16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h12});
`else
        check_frame(16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h12});
`endif
        apply_stimulus(1'b0, 1'b1, 16'h0500);
        step(1);
        apply_stimulus(1'b1, 1'b0, 16'h0);
        step(1);
`ifdef LEADING_ZERO_BLANK_EN
        check_frame(16'hFBDE, {7'h7F, 7'h12, 7'h40, 7'h40});
`else
        check_frame(16'h7BDE, {7'h40, 7'h12, 7'h40, 7'h40});
`endif

        for (int c = 0; c < 3000; c++) begin
            apply_stimulus(($urandom_range(0, 99) < 97) ? 1'b1 : 1'b0,
                           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, rand_val());
            if (c % 700 == 350) begin
                #3 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end else begin
                step(1);
            end
        end

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
